// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory behind a valid/ready request port, returning a one-cycle response.
// Latency: accept at edge N, the resp_valid cycle ends at edge N+1+WAIT_STATES. Throughput: one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready is high only in IDLE. The response cannot be stalled, so the consumer must take it in its valid cycle.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS) + 2,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;

    // Request fields latched at accept; the live inputs are ignored afterwards.
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] widx;
    logic [1:0]        lane;
    logic              legal_f3;
    logic              misaligned;
    logic              fault;
    logic [31:0]       rword;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    assign widx = addr_q[ADDR_W-1:2];
    assign lane = addr_q[1:0];

    // Classify the latched request: a legal funct3 for its direction, and natural alignment for its size.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        case (f3_q)
            3'b000: legal_f3 = 1'b1;
            3'b001: begin
                legal_f3   = 1'b1;
                misaligned = addr_q[0];
            end
            3'b010: begin
                legal_f3   = 1'b1;
                misaligned = |addr_q[1:0];
            end
            3'b100: legal_f3 = !we_q;
            3'b101: begin
                legal_f3   = !we_q;
                misaligned = addr_q[0];
            end
            default: legal_f3 = 1'b0;
        endcase
        fault = !legal_f3 || misaligned;
    end

    // Load path: select the byte or half by lane, then sign- or zero-extend. funct3[2] selects the unsigned variants.
    always_comb begin
        rword   = mem[widx];
        ld_byte = rword[{lane, 3'b000} +: 8];
        ld_half = rword[{addr_q[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   ld_data = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rword;
        endcase
    end

    // FSM state and wait counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode. The response fields are driven only in RESP, so they read 0 at every other time.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_fault = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                cnt_nxt   = 4'd0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (WS == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt + 4'd1 == WS) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault;
                resp_rdata = (fault || we_q) ? 32'h0 : ld_data;
                cnt_nxt    = 4'd0;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Commit the store at the edge that ends RESP. Reset at that edge, or a fault, suppresses the write. The array is never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_RESP && we_q && !fault) begin
            case (f3_q[1:0])
                2'b00:   mem[widx][{lane, 3'b000} +: 8]      <= wdata_q[7:0];
                2'b01:   mem[widx][{addr_q[1], 4'b0000} +: 16] <= wdata_q[15:0];
                default: mem[widx]                           <= wdata_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl. The reference model is a 256-byte array.
// The driver pushes the expected response when it issues a request.
// The monitor pops and compares that entry on every resp_valid.
module tb_data_mem_ctrl;
    localparam int W  = 1;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;

    data_mem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(AW), .WAIT_STATES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [256];

    typedef struct {
        logic [31:0] rd;
        bit          flt;
        int          acc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int last_acc = -1;
    bit in_burst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour computed from the RV32 access rules on a flat byte array.
    task automatic model(input bit we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, input bit commit,
                         output bit flt, output logic [31:0] rd);
        int size;
        bit legal;
        logic [31:0] v;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        flt  = !legal || ((int'(a) % size) != 0);
        rd   = 32'h0;
        if (!flt) begin
            if (we) begin
                if (commit)
                    for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
                if (!f3[2] && size < 4 && v[8*size-1])
                    v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endtask

    // Present a request and wait (bounded) for acceptance, then push the expected response.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                         input bit commit, input bit use_exp, input logic [31:0] exp_rd,
                         input bit exp_f, input bit hold);
        int t;
        bit flt;
        logic [31:0] rd;
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, a, wd, commit, flt, rd);
        e.rd  = use_exp ? exp_rd : rd;
        e.flt = use_exp ? exp_f : flt;
        e.acc = edge_cnt + 1;
        if (in_burst && last_acc >= 0) check("throughput", e.acc - last_acc, W + 2);
        last_acc = e.acc;
        sbq.push_back(e);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic op(input bit we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        issue(we, f3, a, wd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic opx(input bit we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ef);
        issue(we, f3, a, wd, 1'b1, 1'b1, er, ef, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'h0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        check({tag, "_resp_fault"}, {31'h0, resp_fault}, 32'd0);
    endtask

    // Monitor: pop and compare on every response, and require req_ready low while a request is in flight.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                check("ready_low_resp", {31'h0, req_ready}, 32'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding");
                end else begin
                    mon_e = sbq.pop_front();
                    check("rdata", resp_rdata, mon_e.rd);
                    check("fault", {31'h0, resp_fault}, {31'h0, mon_e.flt});
                    check("latency", edge_cnt + 1 - mon_e.acc, W + 1);
                end
            end else if (sbq.size() > 0 && sbq[0].acc <= edge_cnt) begin
                check("ready_low_wait", {31'h0, req_ready}, 32'd0);
            end
        end
    end

    initial begin
        int t;
        logic [2:0] f3;
        logic [7:0] a;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value so that later loads never read uninitialised storage.
        for (int w = 0; w < 64; w++) op(1'b1, 3'd2, 8'(w * 4), $urandom);

        // Word store followed by a word load.
        opx(1'b1, 3'd2, 8'h08, 32'h11223344, 32'h0, 1'b0);
        opx(1'b0, 3'd2, 8'h08, 32'h0, 32'h11223344, 1'b0);

        // Byte store, then signed and unsigned byte loads.
        opx(1'b1, 3'd0, 8'h09, 32'h000000CD, 32'h0, 1'b0);
        opx(1'b0, 3'd2, 8'h08, 32'h0, 32'h1122CD44, 1'b0);
        opx(1'b0, 3'd0, 8'h09, 32'h0, 32'hFFFFFFCD, 1'b0);
        opx(1'b0, 3'd4, 8'h09, 32'h0, 32'h000000CD, 1'b0);

        // High-half store. The low lanes must be preserved.
        opx(1'b1, 3'd2, 8'h0C, 32'h00005566, 32'h0, 1'b0);
        opx(1'b1, 3'd1, 8'h0E, 32'hAAAA8001, 32'h0, 1'b0);
        opx(1'b0, 3'd2, 8'h0C, 32'h0, 32'h80015566, 1'b0);
        opx(1'b0, 3'd1, 8'h0E, 32'h0, 32'hFFFF8001, 1'b0);
        opx(1'b0, 3'd5, 8'h0E, 32'h0, 32'h00008001, 1'b0);

        // Faults return rdata=0 and must leave memory untouched.
        opx(1'b0, 3'd2, 8'h05, 32'h0, 32'h0, 1'b1);
        opx(1'b1, 3'd1, 8'h03, 32'h0000FFFF, 32'h0, 1'b1);
        opx(1'b0, 3'd3, 8'h08, 32'h0, 32'h0, 1'b1);
        opx(1'b1, 3'd3, 8'h08, 32'hDEADBEEF, 32'h0, 1'b1);
        opx(1'b1, 3'd4, 8'h08, 32'hDEADBEEF, 32'h0, 1'b1);
        opx(1'b0, 3'd2, 8'h08, 32'h0, 32'h1122CD44, 1'b0);
        op(1'b0, 3'd2, 8'h00, 32'h0);

        // Hold req_valid high across a burst. Accepts must be exactly W+2 edges apart.
        in_burst = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 8; i++)
            issue(1'b0, 3'd2, 8'($urandom_range(0, 63) * 4), 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, i < 7);
        in_burst = 1'b0;

        // Reset during WAIT: the store is dropped and no response appears.
        issue(1'b1, 3'd2, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        op(1'b0, 3'd2, 8'h10, 32'h0);

        // Random mix of loads and stores, biased towards aligned addresses.
        for (int i = 0; i < 300; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'b11)
                a = a & ~8'((1 << f3[1:0]) - 1);
            op(1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still outstanding, expected 0", sbq.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
